// File: rtl/mem_addr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_addr_pkg
// Description : Shared types and constants for the memory address selector.
//               Holds the exception-sequencer state encoding, exception cause
//               codes and the default exception vector base address.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_addr_pkg;

    // Exception-sequencer states: idle, vector fetch in flight, handler capture
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VEC  = 2'd1,
        ST_CAPT = 2'd2
    } state_t;

    // Exception cause codes (value 3 is reserved)
    localparam logic [1:0] EXC_OPCODE   = 2'd0;
    localparam logic [1:0] EXC_OVERFLOW = 2'd1;
    localparam logic [1:0] EXC_DIV0     = 2'd2;

    // Byte address of the first exception vector entry
    localparam int VEC_BASE_DEFAULT = 253;

    // Latency counter width; memory latency is at most 7 cycles
    localparam int CNT_W = 3;

endpackage
`default_nettype wire

// File: rtl/excpt_vec_seq.sv
`default_nettype none
// ============================================================================
// Module      : excpt_vec_seq
// Description : Exception vector sequencer. From IDLE an exception request
//               launches a vector read (VEC) lasting MEM_LAT cycles, then the
//               returned byte is latched as the handler address and a one-cycle
//               CAPT state signals completion.
// Ports       : clk, reset      - clock, asynchronous active-high reset
//               excpt_req       - exception request (sampled in IDLE only)
//               mem_byte        - memory read data byte
//               vec_start       - IDLE and excpt_req: vector address loads now
//               busy            - sequence in progress (VEC or CAPT)
//               excpt_done      - one-cycle pulse in CAPT
//               handler_pc      - registered, zero-extended handler address
// Revision    : 1.0 - initial release
// ============================================================================
module excpt_vec_seq
    import mem_addr_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             excpt_req,
    input  logic [7:0]       mem_byte,
    output logic             vec_start,
    output logic             busy,
    output logic             excpt_done,
    output logic [WIDTH-1:0] handler_pc
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MEM_LAT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_capt;
    logic [WIDTH-1:0]   r_handler_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_handler_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capt) begin
                r_handler_pc <= WIDTH'(mem_byte);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capt      = 1'b0;
        vec_start   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (excpt_req) begin
                    vec_start   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_VEC;
                end
            end
            ST_VEC: begin
                // The byte is sampled on the edge that ends the last VEC cycle
                if (r_cnt == c_cnt_last) begin
                    w_capt      = 1'b1;
                    w_state_nxt = ST_CAPT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_CAPT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Decoded straight from the state register so reset clears them at once
    assign busy       = (r_state != ST_IDLE);
    assign excpt_done = (r_state == ST_CAPT);
    assign handler_pc = r_handler_pc;

endmodule
`default_nettype wire

// File: rtl/mem_addr_sel.sv
`default_nettype none
// ============================================================================
// Module      : mem_addr_sel
// Description : Memory address selector. Loads one of NUM_SRC address sources
//               into a registered memory address, or on an exception request
//               drives the exception vector address and runs the vector
//               fetch sequence (excpt_vec_seq) to obtain the handler address.
//               Optional macro MEM_ADDR_ALIGN_CHK_EN adds a registered
//               misaligned-word flag; without it misalign is tied low.
// Ports       : clk, reset      - clock, asynchronous active-high reset
//               sel, src        - source select, flattened sources
//               ld              - load selected source into addr_out
//               word_acc        - word access (alignment check only)
//               excpt_req       - exception request
//               excpt_code      - exception cause
//               mem_byte        - memory read data byte
//               addr_out        - registered memory address
//               busy            - exception sequence in progress
//               handler_pc      - registered handler address
//               excpt_done      - one-cycle completion pulse
//               misalign        - registered misaligned-word flag
// Revision    : 1.0 - initial release
// ============================================================================
module mem_addr_sel
    import mem_addr_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int NUM_SRC  = 4,
    parameter  int VEC_BASE = VEC_BASE_DEFAULT,
    parameter  int MEM_LAT  = 1,
    localparam int SEL_W    = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SRC*WIDTH-1:0] src,
    input  logic                     ld,
    input  logic                     word_acc,
    input  logic                     excpt_req,
    input  logic [1:0]               excpt_code,
    input  logic [7:0]               mem_byte,
    output logic [WIDTH-1:0]         addr_out,
    output logic                     busy,
    output logic [WIDTH-1:0]         handler_pc,
    output logic                     excpt_done,
    output logic                     misalign
);

    localparam logic [WIDTH-1:0] c_vec_base = WIDTH'(VEC_BASE);

    logic [WIDTH-1:0] w_src_sel;
    logic [WIDTH-1:0] w_vec_addr;
    logic             w_vec_start;
    logic             w_load;
    logic [WIDTH-1:0] r_addr;

    // Out-of-range selects fall through to zero
    always_comb begin
        w_src_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(sel) == i) begin
                w_src_sel = src[i*WIDTH +: WIDTH];
            end
        end
    end

    // Wraps modulo 2^WIDTH by construction
    assign w_vec_addr = c_vec_base + WIDTH'(excpt_code);

    // An exception request in IDLE wins over a load in the same cycle
    assign w_load = ld && !busy && !w_vec_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
        end else if (w_vec_start) begin
            r_addr <= w_vec_addr;
        end else if (w_load) begin
            r_addr <= w_src_sel;
        end
    end

    assign addr_out = r_addr;

`ifdef MEM_ADDR_ALIGN_CHK_EN
    logic r_misalign;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_load && word_acc && (w_src_sel[1:0] != 2'b00);
        end
    end

    assign misalign = r_misalign;
`else
    logic w_unused_word_acc;

    assign w_unused_word_acc = word_acc;
    assign misalign          = 1'b0;
`endif

    excpt_vec_seq #(
        .WIDTH   (WIDTH),
        .MEM_LAT (MEM_LAT)
    ) u_seq (
        .clk        (clk),
        .reset      (reset),
        .excpt_req  (excpt_req),
        .mem_byte   (mem_byte),
        .vec_start  (w_vec_start),
        .busy       (busy),
        .excpt_done (excpt_done),
        .handler_pc (handler_pc)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_addr_sel.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_addr_sel
// Description : Self-checking bench for mem_addr_sel. Three instances:
//               a (defaults, MEM_LAT=1), c (MEM_LAT=3) and b (WIDTH=8,
//               NUM_SRC=3, VEC_BASE=254). Instance a runs a vector table whose
//               expected outputs go through a queue; c and b run short
//               hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_addr_sel;

`ifdef MEM_ADDR_ALIGN_CHK_EN
    localparam bit c_aln_en = 1'b1;
`else
    localparam bit c_aln_en = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  sel = '0;
    logic        ld = 1'b0;
    logic        word_acc = 1'b0;
    logic        excpt_req = 1'b0;
    logic [1:0]  excpt_code = '0;
    logic [7:0]  mem_byte = '0;
    logic [127:0] src_a;
    logic [23:0]  src_b;

    logic [31:0] addr_a, hp_a, addr_c, hp_c;
    logic [7:0]  addr_b, hp_b;
    logic        busy_a, done_a, mis_a;
    logic        busy_c, done_c, mis_c;
    logic        busy_b, done_b, mis_b;

    assign src_a = {32'h0000_3003, 32'h0000_2000, 32'h0000_1004, 32'h0000_0002};
    assign src_b = {8'h33, 8'h22, 8'h11};

    always #5 clk = ~clk;

    mem_addr_sel dut_a (
        .clk(clk), .reset(reset), .sel(sel), .src(src_a), .ld(ld),
        .word_acc(word_acc), .excpt_req(excpt_req), .excpt_code(excpt_code),
        .mem_byte(mem_byte), .addr_out(addr_a), .busy(busy_a),
        .handler_pc(hp_a), .excpt_done(done_a), .misalign(mis_a)
    );

    mem_addr_sel #(.MEM_LAT(3)) dut_c (
        .clk(clk), .reset(reset), .sel(sel), .src(src_a), .ld(ld),
        .word_acc(word_acc), .excpt_req(excpt_req), .excpt_code(excpt_code),
        .mem_byte(mem_byte), .addr_out(addr_c), .busy(busy_c),
        .handler_pc(hp_c), .excpt_done(done_c), .misalign(mis_c)
    );

    mem_addr_sel #(.WIDTH(8), .NUM_SRC(3), .VEC_BASE(254), .MEM_LAT(1)) dut_b (
        .clk(clk), .reset(reset), .sel(sel), .src(src_b), .ld(ld),
        .word_acc(word_acc), .excpt_req(excpt_req), .excpt_code(excpt_code),
        .mem_byte(mem_byte), .addr_out(addr_b), .busy(busy_b),
        .handler_pc(hp_b), .excpt_done(done_b), .misalign(mis_b)
    );

    typedef struct {
        logic        ld;
        logic [1:0]  sel;
        logic        req;
        logic [1:0]  code;
        logic        wacc;
        logic [7:0]  mbyte;
        logic [31:0] e_addr;
        logic        e_busy;
        logic        e_done;
        logic [31:0] e_hp;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        busy;
        logic        done;
        logic [31:0] hp;
        logic        mis;
    } exp_t;

    vec_t tbl [16];
    exp_t sbq [$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        //            ld    sel   req   code  wacc  mbyte  addr          busy  done  hp           mis
        tbl[0]  = '{1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 8'h00, 32'h0000_1004, 1'b0, 1'b0, 32'h00, 1'b0};
        tbl[1]  = '{1'b0, 2'd1, 1'b0, 2'd0, 1'b0, 8'h00, 32'h0000_1004, 1'b0, 1'b0, 32'h00, 1'b0};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 8'h00, 32'h0000_0002, 1'b0, 1'b0, 32'h00, 1'b1};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 8'h00, 32'h0000_0002, 1'b0, 1'b0, 32'h00, 1'b0};
        tbl[4]  = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 8'h00, 32'h0000_0002, 1'b0, 1'b0, 32'h00, 1'b0};
        tbl[5]  = '{1'b1, 2'd3, 1'b0, 2'd0, 1'b1, 8'h00, 32'h0000_3003, 1'b0, 1'b0, 32'h00, 1'b1};
        tbl[6]  = '{1'b1, 2'd2, 1'b1, 2'd1, 1'b0, 8'h40, 32'd254,      1'b1, 1'b0, 32'h00, 1'b0};
        tbl[7]  = '{1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 8'h40, 32'd254,      1'b1, 1'b1, 32'h40, 1'b0};
        tbl[8]  = '{1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 8'h99, 32'd254,      1'b0, 1'b0, 32'h40, 1'b0};
        tbl[9]  = '{1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 8'h00, 32'h0000_1004, 1'b0, 1'b0, 32'h40, 1'b0};
        tbl[10] = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 8'h00, 32'd253,      1'b1, 1'b0, 32'h40, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 8'h7F, 32'd253,      1'b1, 1'b1, 32'h7F, 1'b0};
        tbl[12] = '{1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 8'h00, 32'd253,      1'b0, 1'b0, 32'h7F, 1'b0};
        tbl[13] = '{1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 8'h00, 32'd256,      1'b1, 1'b0, 32'h7F, 1'b0};
        tbl[14] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 8'hFF, 32'd256,      1'b1, 1'b1, 32'hFF, 1'b0};
        tbl[15] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 8'h00, 32'd256,      1'b0, 1'b0, 32'hFF, 1'b0};

        // Reset state, before any clock edge
        #2;
        chk("rst addr_a", addr_a, 32'h0);
        chk("rst busy_a", {31'b0, busy_a}, 32'h0);
        chk("rst done_a", {31'b0, done_a}, 32'h0);
        chk("rst hp_a", hp_a, 32'h0);
        chk("rst mis_a", {31'b0, mis_a}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Vector table through the scoreboard queue (instance a)
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ld = tbl[i].ld; sel = tbl[i].sel; excpt_req = tbl[i].req;
            excpt_code = tbl[i].code; word_acc = tbl[i].wacc; mem_byte = tbl[i].mbyte;
            sbq.push_back('{tbl[i].e_addr, tbl[i].e_busy, tbl[i].e_done,
                            tbl[i].e_hp, tbl[i].e_mis & c_aln_en});
            @(posedge clk);
            #1;
            e = sbq.pop_front();
            chk($sformatf("v%0d addr", i), addr_a, e.addr);
            chk($sformatf("v%0d busy", i), {31'b0, busy_a}, {31'b0, e.busy});
            chk($sformatf("v%0d done", i), {31'b0, done_a}, {31'b0, e.done});
            chk($sformatf("v%0d hp", i), hp_a, e.hp);
            chk($sformatf("v%0d mis", i), {31'b0, mis_a}, {31'b0, e.mis});
        end

        // Reset in the middle of VEC aborts the sequence
        @(negedge clk);
        ld = 1'b0; word_acc = 1'b0; excpt_req = 1'b1; excpt_code = 2'd2; mem_byte = 8'h11;
        @(posedge clk);
        #1;
        chk("abort vec addr", addr_a, 32'd255);
        chk("abort vec busy", {31'b0, busy_a}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        excpt_req = 1'b0;
        #1;
        chk("abort rst addr", addr_a, 32'h0);
        chk("abort rst busy", {31'b0, busy_a}, 32'h0);
        chk("abort rst done", {31'b0, done_a}, 32'h0);
        chk("abort rst hp", hp_a, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post-abort done %0d", k), {31'b0, done_a}, 32'h0);
            chk($sformatf("post-abort busy %0d", k), {31'b0, busy_a}, 32'h0);
        end

        // MEM_LAT=3: vector address held three cycles, loads ignored
        @(negedge clk);
        excpt_req = 1'b1; excpt_code = 2'd2; ld = 1'b0; mem_byte = 8'h5A;
        @(posedge clk);
        #1;
        chk("lat3 vec0 addr", addr_c, 32'd255);
        chk("lat3 vec0 busy", {31'b0, busy_c}, 32'h1);
        chk("lat3 vec0 done", {31'b0, done_c}, 32'h0);
        @(negedge clk);
        excpt_req = 1'b0; ld = 1'b1; sel = 2'd1;
        for (int k = 1; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("lat3 vec%0d addr", k), addr_c, 32'd255);
            chk($sformatf("lat3 vec%0d busy", k), {31'b0, busy_c}, 32'h1);
            chk($sformatf("lat3 vec%0d done", k), {31'b0, done_c}, 32'h0);
        end
        @(posedge clk);
        #1;
        chk("lat3 capt done", {31'b0, done_c}, 32'h1);
        chk("lat3 capt hp", hp_c, 32'h0000_005A);
        chk("lat3 capt addr", addr_c, 32'd255);
        @(negedge clk);
        ld = 1'b0;
        @(posedge clk);
        #1;
        chk("lat3 idle done", {31'b0, done_c}, 32'h0);
        chk("lat3 idle busy", {31'b0, busy_c}, 32'h0);
        chk("lat3 idle addr", addr_c, 32'd255);

        // WIDTH=8, NUM_SRC=3: out-of-range select and vector wrap
        @(negedge clk);
        ld = 1'b1; sel = 2'd1; excpt_req = 1'b0;
        @(posedge clk);
        #1;
        chk("w8 sel1 addr", {24'b0, addr_b}, 32'h22);
        @(negedge clk);
        sel = 2'd3;
        @(posedge clk);
        #1;
        chk("w8 sel3 addr", {24'b0, addr_b}, 32'h0);
        @(negedge clk);
        ld = 1'b0; excpt_req = 1'b1; excpt_code = 2'd3; mem_byte = 8'hC3;
        @(posedge clk);
        #1;
        chk("w8 wrap addr", {24'b0, addr_b}, 32'h1);
        chk("w8 wrap busy", {31'b0, busy_b}, 32'h1);
        @(negedge clk);
        excpt_req = 1'b0;
        @(posedge clk);
        #1;
        chk("w8 done", {31'b0, done_b}, 32'h1);
        chk("w8 hp", {24'b0, hp_b}, 32'hC3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_addr_sel.md
MEM_ADDR_SEL -- requirements
Module: mem_addr_sel

Interface
REQ-001 Parameter WIDTH, default 32, address width in bits.
REQ-002 Parameter NUM_SRC, default 4, number of address sources (2..16); SEL_W = clog2(NUM_SRC).
REQ-003 Parameter VEC_BASE, default 253, memory address of the first exception vector byte.
REQ-004 Parameter MEM_LAT, default 1, memory read latency in cycles (1..7).
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 sel  in  SEL_W  source select.
REQ-008 src  in  NUM_SRC*WIDTH  flattened sources; source i at bits [i*WIDTH +: WIDTH]; defaults 0=PC, 1=ALUOut, 2=ALU_Result, 3=exception handler address.
REQ-009 ld  in  1  load the selected source into addr_out.
REQ-010 word_acc  in  1  current access is a word access (alignment check only).
REQ-011 excpt_req  in  1  exception request, sampled while idle.
REQ-012 excpt_code  in  2  exception cause: 0 invalid opcode, 1 overflow, 2 divide by zero, 3 reserved.
REQ-013 mem_byte  in  8  memory read data byte.
REQ-014 addr_out  out  WIDTH  registered memory address.
REQ-015 busy  out  1  exception sequence in progress.
REQ-016 handler_pc  out  WIDTH  registered handler address: mem_byte zero-extended.
REQ-017 excpt_done  out  1  one-cycle pulse; handler_pc valid.
REQ-018 misalign  out  1  registered misaligned-word flag.

Function
REQ-019 FSM states: IDLE, VEC, CAPT; busy = 1 in VEC and CAPT.
REQ-020 IDLE, ld=1, excpt_req=0: next edge addr_out <= src[sel]; one-cycle latency.
REQ-021 IDLE, ld=0, excpt_req=0: addr_out holds.
REQ-022 sel >= NUM_SRC with ld=1: addr_out <= 0.
REQ-023 IDLE, excpt_req=1: takes priority over ld; next edge addr_out <= VEC_BASE + excpt_code (WIDTH-bit add, wraps modulo 2^WIDTH), latency counter cleared, state -> VEC.
REQ-024 VEC lasts exactly MEM_LAT cycles; ld, sel and excpt_req ignored; addr_out holds the vector address.
REQ-025 At the edge ending the last VEC cycle: handler_pc <= {zeros, mem_byte}, state -> CAPT.
REQ-026 CAPT lasts one cycle; excpt_done = 1 only in CAPT; next state IDLE; ld ignored in CAPT.
REQ-027 excpt_req still high on return to IDLE starts a new sequence; requests arriving while busy are not queued.
REQ-028 handler_pc holds between sequences.

Reset
REQ-029 Reset asserted: state IDLE, counter 0, addr_out 0, handler_pc 0, busy 0, excpt_done 0, misalign 0, immediately and without a clock edge.
REQ-030 Reset during VEC or CAPT aborts the sequence; no excpt_done pulse follows deassertion.

Configuration
REQ-031 MEM_ADDR_ALIGN_CHK_EN defined: on an IDLE load with ld=1 and word_acc=1, misalign <= (src[sel][1:0] != 0) at the same edge as addr_out; otherwise misalign <= 0; addr_out loads regardless.
REQ-032 MEM_ADDR_ALIGN_CHK_EN undefined: misalign tied 0; word_acc unused.

Structure
REQ-033 Package mem_addr_pkg holds the FSM state type, cause codes (EXC_OPCODE=0, EXC_OVERFLOW=1, EXC_DIV0=2) and the VEC_BASE default.
REQ-034 One sub-module, excpt_vec_seq, contains the FSM, latency counter and handler_pc register; the source mux and addr_out register stay in the top level.

Verification
REQ-035 Reset, then ld=1, sel=1, src[1]=0x0000_1004 -> addr_out=0x0000_1004 one edge later; busy=0.
REQ-036 ld=1, sel=2, excpt_req=1, code=1 in the same cycle -> addr_out=254, busy=1; MEM_LAT=1, mem_byte=0x40 -> excpt_done=1 two cycles after request, handler_pc=0x0000_0040.
REQ-037 MEM_LAT=3, code=2 -> addr_out=255 for 3 cycles, ld pulses ignored, then one-cycle excpt_done.
REQ-038 Reset asserted during VEC -> all outputs 0 immediately; no excpt_done after release.
REQ-039 Macro defined: ld=1, word_acc=1, src[0]=0x0000_0002 -> misalign=1 for one cycle, addr_out=0x0000_0002; word_acc=0 -> misalign=0.
REQ-040 NUM_SRC=3, sel=3, ld=1 -> addr_out=0; WIDTH=8, VEC_BASE=254, code=3 -> addr_out wraps to 1.
